// File: rtl/dt_leg_sequencer_if.sv
// Bundle of the register-side write port, sequencing controls and active leg configuration
// outputs for dt_leg_sequencer.
interface dt_leg_sequencer_if #(
  parameter int unsigned NLEGS = 4,
  parameter int unsigned DTW   = 8
);
  logic                  i_wr_en;
  logic [2:0]            i_wr_leg;
  logic [DTW-1:0]        i_wr_dta;
  logic [DTW-1:0]        i_wr_dtb;
  logic [1:0]            i_wr_logic;
  logic                  i_wr_dten;
  logic                  i_start;
  logic                  i_stop;
  logic                  i_sync;
  logic                  i_fault;
  logic                  i_fault_clr;
  logic [NLEGS*DTW-1:0]  o_dtime_a;
  logic [NLEGS*DTW-1:0]  o_dtime_b;
  logic [NLEGS-1:0]      o_logic_a;
  logic [NLEGS-1:0]      o_logic_b;
  logic [NLEGS-1:0]      o_dt_onoff;
  logic                  o_pwm_onoff;
  logic [NLEGS-1:0]      o_pending;
  logic                  o_wr_err;
  logic [2:0]            o_state;

  modport master (
    output i_wr_en, i_wr_leg, i_wr_dta, i_wr_dtb, i_wr_logic, i_wr_dten,
    output i_start, i_stop, i_sync, i_fault, i_fault_clr,
    input  o_dtime_a, o_dtime_b, o_logic_a, o_logic_b, o_dt_onoff,
    input  o_pwm_onoff, o_pending, o_wr_err, o_state
  );

  modport slave (
    input  i_wr_en, i_wr_leg, i_wr_dta, i_wr_dtb, i_wr_logic, i_wr_dten,
    input  i_start, i_stop, i_sync, i_fault, i_fault_clr,
    output o_dtime_a, o_dtime_b, o_logic_a, o_logic_b, o_dt_onoff,
    output o_pwm_onoff, o_pending, o_wr_err, o_state
  );
endinterface

// File: rtl/dt_leg_sequencer.sv
// Shadow/active configuration owner for NLEGS dead-time generators plus the global
// pwm_onoff start/stop/fault sequencer.
module dt_leg_sequencer #(
  parameter int unsigned NLEGS  = 4,
  parameter int unsigned DTW    = 8,
  parameter int unsigned DT_MIN = 2,
  parameter int unsigned DT_RST = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  dt_leg_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StArming   = 3'd1,
    StRun      = 3'd2,
    StStopping = 3'd3,
    StFault    = 3'd4
  } state_e;

  localparam logic [DTW-1:0] DtMin = DTW'(DT_MIN);
  localparam logic [DTW-1:0] DtRst = DTW'(DT_RST);

  state_e r_state, w_state_d;

  logic [DTW-1:0] r_sh_dta [NLEGS];
  logic [DTW-1:0] r_sh_dtb [NLEGS];
  logic [DTW-1:0] r_dta    [NLEGS];
  logic [DTW-1:0] r_dtb    [NLEGS];
  logic [NLEGS-1:0] r_sh_logic_a, r_sh_logic_b, r_sh_dten;
  logic [NLEGS-1:0] r_logic_a, r_logic_b, r_dten;
  logic [NLEGS-1:0] r_pending, w_pending_d;
  logic [NLEGS-1:0] w_wr_mask, w_commit_mask;
  logic             r_wr_err;

  logic           w_wr_valid;
  logic           w_wr_inval;
  logic           w_commit_ok;
  logic [DTW-1:0] w_dta_cl;
  logic [DTW-1:0] w_dtb_cl;

  assign w_wr_valid = bus.i_wr_en && (32'(bus.i_wr_leg) < NLEGS);
  assign w_wr_inval = bus.i_wr_en && !(32'(bus.i_wr_leg) < NLEGS);

  // Clamp only matters when dead time is actually inserted.
  assign w_dta_cl = (bus.i_wr_dten && (bus.i_wr_dta < DtMin)) ? DtMin : bus.i_wr_dta;
  assign w_dtb_cl = (bus.i_wr_dten && (bus.i_wr_dtb < DtMin)) ? DtMin : bus.i_wr_dtb;

  // Outputs are off in IDLE/FAULT so commits may land any cycle; otherwise wait for sync.
  assign w_commit_ok = (r_state == StIdle) || (r_state == StFault) || bus.i_sync;

  always_comb begin
    w_wr_mask = '0;
    for (int unsigned i = 0; i < NLEGS; i++) begin
      w_wr_mask[i] = w_wr_valid && (bus.i_wr_leg == 3'(i));
    end
    w_commit_mask = w_commit_ok ? r_pending : '0;
    // A write in the commit cycle re-arms pending for the following commit.
    w_pending_d   = (r_pending & ~w_commit_mask) | w_wr_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NLEGS; i++) begin
        r_sh_dta[i] <= DtRst;
        r_sh_dtb[i] <= DtRst;
        r_dta[i]    <= DtRst;
        r_dtb[i]    <= DtRst;
      end
      r_sh_logic_a <= '1;
      r_sh_logic_b <= '1;
      r_sh_dten    <= '1;
      r_logic_a    <= '1;
      r_logic_b    <= '1;
      r_dten       <= '1;
      r_pending    <= '0;
    end else begin
      for (int unsigned i = 0; i < NLEGS; i++) begin
        if (w_wr_mask[i]) begin
          r_sh_dta[i]     <= w_dta_cl;
          r_sh_dtb[i]     <= w_dtb_cl;
          r_sh_logic_a[i] <= bus.i_wr_logic[0];
          r_sh_logic_b[i] <= bus.i_wr_logic[1];
          r_sh_dten[i]    <= bus.i_wr_dten;
        end
        if (w_commit_mask[i]) begin
          r_dta[i]     <= r_sh_dta[i];
          r_dtb[i]     <= r_sh_dtb[i];
          r_logic_a[i] <= r_sh_logic_a[i];
          r_logic_b[i] <= r_sh_logic_b[i];
          r_dten[i]    <= r_sh_dten[i];
        end
      end
      r_pending <= w_pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_err <= 1'b0;
    end else if (w_wr_inval) begin
      r_wr_err <= 1'b1;
    end else if (bus.i_fault_clr) begin
      r_wr_err <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Priority: fault > stop > start.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.i_fault)      w_state_d = StFault;
        else if (bus.i_stop)  w_state_d = StIdle;
        else if (bus.i_start) w_state_d = StArming;
      end
      StArming: begin
        if (bus.i_fault)     w_state_d = StFault;
        else if (bus.i_stop) w_state_d = StIdle;
        else if (bus.i_sync) w_state_d = StRun;
      end
      StRun: begin
        if (bus.i_fault)     w_state_d = StFault;
        else if (bus.i_stop) w_state_d = StStopping;
      end
      StStopping: begin
        if (bus.i_fault)     w_state_d = StFault;
        else if (bus.i_sync) w_state_d = StIdle;
      end
      StFault: begin
        if (bus.i_fault_clr && !bus.i_fault) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.o_dtime_a = '0;
    bus.o_dtime_b = '0;
    for (int unsigned i = 0; i < NLEGS; i++) begin
      bus.o_dtime_a[i*DTW +: DTW] = r_dta[i];
      bus.o_dtime_b[i*DTW +: DTW] = r_dtb[i];
    end
  end

  assign bus.o_logic_a   = r_logic_a;
  assign bus.o_logic_b   = r_logic_b;
  assign bus.o_dt_onoff  = r_dten;
  assign bus.o_pending   = r_pending;
  assign bus.o_wr_err    = r_wr_err;
  assign bus.o_state     = r_state;
  // Fault gating is combinational so switching stops in the trip cycle.
  assign bus.o_pwm_onoff = ((r_state == StRun) || (r_state == StStopping)) && !bus.i_fault;

endmodule

// File: tb/tb_dt_leg_sequencer.sv
// Directed self-checking bench for dt_leg_sequencer with NLEGS=4, DTW=8.
module tb_dt_leg_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dt_leg_sequencer_if #(.NLEGS(4), .DTW(8)) u_if ();

  dt_leg_sequencer #(
    .NLEGS (4),
    .DTW   (8),
    .DT_MIN(2),
    .DT_RST(10)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (u_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [2:0] leg, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] lg, input logic en);
    u_if.i_wr_en    = 1'b1;
    u_if.i_wr_leg   = leg;
    u_if.i_wr_dta   = a;
    u_if.i_wr_dtb   = b;
    u_if.i_wr_logic = lg;
    u_if.i_wr_dten  = en;
    tick();
    u_if.i_wr_en    = 1'b0;
  endtask

  task automatic pulse_sync();
    u_if.i_sync = 1'b1;
    tick();
    u_if.i_sync = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if (u_if.o_dtime_a !== 32'h0A0A0A0A || u_if.o_dtime_b !== 32'h0A0A0A0A) begin
      n_fail++;
      $display("FAIL reset_dtime got a=%h b=%h want 0a0a0a0a", u_if.o_dtime_a, u_if.o_dtime_b);
    end
    n_tests++;
    if ({u_if.o_logic_a, u_if.o_logic_b, u_if.o_dt_onoff} !== 12'hFFF) begin
      n_fail++;
      $display("FAIL reset_flags got la=%b lb=%b dt=%b want all ones",
               u_if.o_logic_a, u_if.o_logic_b, u_if.o_dt_onoff);
    end
    n_tests++;
    if ({u_if.o_pwm_onoff, u_if.o_state, u_if.o_pending, u_if.o_wr_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got pwm=%b st=%0d pend=%b err=%b want zeros",
               u_if.o_pwm_onoff, u_if.o_state, u_if.o_pending, u_if.o_wr_err);
    end
  endtask

  task automatic test_idle_write();
    do_write(3'd2, 8'd5, 8'd7, 2'b11, 1'b1);
    n_tests++;
    if (u_if.o_pending !== 4'b0100 || u_if.o_dtime_a[16 +: 8] !== 8'd10) begin
      n_fail++;
      $display("FAIL idle_pend got pend=%b a2=%0d want 0100/10",
               u_if.o_pending, u_if.o_dtime_a[16 +: 8]);
    end
    tick();
    n_tests++;
    if (u_if.o_dtime_a[16 +: 8] !== 8'd5 || u_if.o_dtime_b[16 +: 8] !== 8'd7 ||
        u_if.o_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_commit got a2=%0d b2=%0d pend=%b want 5/7/0000",
               u_if.o_dtime_a[16 +: 8], u_if.o_dtime_b[16 +: 8], u_if.o_pending);
    end
  endtask

  task automatic test_clamp();
    do_write(3'd1, 8'd1, 8'd0, 2'b11, 1'b1);
    tick();
    n_tests++;
    if (u_if.o_dtime_a[8 +: 8] !== 8'd2 || u_if.o_dtime_b[8 +: 8] !== 8'd2 ||
        u_if.o_dt_onoff[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp_on got a1=%0d b1=%0d dt=%b want 2/2/1",
               u_if.o_dtime_a[8 +: 8], u_if.o_dtime_b[8 +: 8], u_if.o_dt_onoff[1]);
    end
    do_write(3'd1, 8'd1, 8'd0, 2'b01, 1'b0);
    tick();
    n_tests++;
    if (u_if.o_dtime_a[8 +: 8] !== 8'd1 || u_if.o_dtime_b[8 +: 8] !== 8'd0 ||
        u_if.o_dt_onoff[1] !== 1'b0 || u_if.o_logic_a[1] !== 1'b1 ||
        u_if.o_logic_b[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_off got a1=%0d b1=%0d dt=%b la=%b lb=%b want 1/0/0/1/0",
               u_if.o_dtime_a[8 +: 8], u_if.o_dtime_b[8 +: 8], u_if.o_dt_onoff[1],
               u_if.o_logic_a[1], u_if.o_logic_b[1]);
    end
  endtask

  task automatic test_arm_run();
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    n_tests++;
    if (u_if.o_state !== 3'd1 || u_if.o_pwm_onoff !== 1'b0) begin
      n_fail++;
      $display("FAIL arming got st=%0d pwm=%b want 1/0", u_if.o_state, u_if.o_pwm_onoff);
    end
    pulse_sync();
    n_tests++;
    if (u_if.o_state !== 3'd2 || u_if.o_pwm_onoff !== 1'b1) begin
      n_fail++;
      $display("FAIL run_entry got st=%0d pwm=%b want 2/1", u_if.o_state, u_if.o_pwm_onoff);
    end
  endtask

  task automatic test_run_write();
    do_write(3'd0, 8'd9, 8'd9, 2'b11, 1'b1);
    tick();
    tick();
    n_tests++;
    if (u_if.o_dtime_a[0 +: 8] !== 8'd10 || u_if.o_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL run_hold got a0=%0d pend=%b want 10/0001",
               u_if.o_dtime_a[0 +: 8], u_if.o_pending);
    end
    pulse_sync();
    n_tests++;
    if (u_if.o_dtime_a[0 +: 8] !== 8'd9 || u_if.o_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL run_commit got a0=%0d pend=%b want 9/0000",
               u_if.o_dtime_a[0 +: 8], u_if.o_pending);
    end
    u_if.i_sync = 1'b1;
    do_write(3'd0, 8'd12, 8'd12, 2'b11, 1'b1);
    u_if.i_sync = 1'b0;
    tick();
    n_tests++;
    if (u_if.o_dtime_a[0 +: 8] !== 8'd9 || u_if.o_pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL run_defer got a0=%0d pend=%b want 9/0001",
               u_if.o_dtime_a[0 +: 8], u_if.o_pending);
    end
    pulse_sync();
    n_tests++;
    if (u_if.o_dtime_a[0 +: 8] !== 8'd12 || u_if.o_dtime_b[0 +: 8] !== 8'd12) begin
      n_fail++;
      $display("FAIL run_defer_commit got a0=%0d b0=%0d want 12/12",
               u_if.o_dtime_a[0 +: 8], u_if.o_dtime_b[0 +: 8]);
    end
  endtask

  task automatic test_stop();
    u_if.i_stop = 1'b1;
    tick();
    u_if.i_stop = 1'b0;
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    n_tests++;
    if (u_if.o_state !== 3'd3 || u_if.o_pwm_onoff !== 1'b1) begin
      n_fail++;
      $display("FAIL stopping got st=%0d pwm=%b want 3/1", u_if.o_state, u_if.o_pwm_onoff);
    end
    pulse_sync();
    n_tests++;
    if (u_if.o_state !== 3'd0 || u_if.o_pwm_onoff !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_done got st=%0d pwm=%b want 0/0", u_if.o_state, u_if.o_pwm_onoff);
    end
  endtask

  task automatic test_fault();
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    pulse_sync();
    u_if.i_fault = 1'b1;
    #1;
    n_tests++;
    if (u_if.o_pwm_onoff !== 1'b0 || u_if.o_state !== 3'd2) begin
      n_fail++;
      $display("FAIL fault_gate got pwm=%b st=%0d want 0/2", u_if.o_pwm_onoff, u_if.o_state);
    end
    tick();
    u_if.i_fault_clr = 1'b1;
    tick();
    u_if.i_fault_clr = 1'b0;
    n_tests++;
    if (u_if.o_state !== 3'd4 || u_if.o_pwm_onoff !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_hold got st=%0d pwm=%b want 4/0", u_if.o_state, u_if.o_pwm_onoff);
    end
    u_if.i_fault = 1'b0;
    tick();
    n_tests++;
    if (u_if.o_state !== 3'd4) begin
      n_fail++;
      $display("FAIL fault_noclr got st=%0d want 4", u_if.o_state);
    end
    u_if.i_fault_clr = 1'b1;
    tick();
    u_if.i_fault_clr = 1'b0;
    n_tests++;
    if (u_if.o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL fault_clear got st=%0d want 0", u_if.o_state);
    end
  endtask

  task automatic test_wr_err();
    do_write(3'd6, 8'd33, 8'd44, 2'b00, 1'b0);
    tick();
    n_tests++;
    if (u_if.o_wr_err !== 1'b1 || u_if.o_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL wr_err_set got err=%b pend=%b want 1/0000", u_if.o_wr_err, u_if.o_pending);
    end
    n_tests++;
    if (u_if.o_dtime_a !== {8'd10, 8'd5, 8'd1, 8'd12} ||
        u_if.o_dtime_b !== {8'd10, 8'd7, 8'd0, 8'd12}) begin
      n_fail++;
      $display("FAIL wr_err_dtime got a=%h b=%h want 0a05010c/0a07000c",
               u_if.o_dtime_a, u_if.o_dtime_b);
    end
    n_tests++;
    if (u_if.o_logic_a !== 4'b1111 || u_if.o_logic_b !== 4'b1101 ||
        u_if.o_dt_onoff !== 4'b1101) begin
      n_fail++;
      $display("FAIL wr_err_flags got la=%b lb=%b dt=%b want 1111/1101/1101",
               u_if.o_logic_a, u_if.o_logic_b, u_if.o_dt_onoff);
    end
    u_if.i_fault_clr = 1'b1;
    tick();
    u_if.i_fault_clr = 1'b0;
    n_tests++;
    if (u_if.o_wr_err !== 1'b0 || u_if.o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL wr_err_clr got err=%b st=%0d want 0/0", u_if.o_wr_err, u_if.o_state);
    end
  endtask

  task automatic test_start_stop();
    u_if.i_start = 1'b1;
    u_if.i_stop  = 1'b1;
    tick();
    n_tests++;
    if (u_if.o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL ss_idle got st=%0d want 0", u_if.o_state);
    end
    u_if.i_stop = 1'b0;
    tick();
    u_if.i_stop = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    u_if.i_stop  = 1'b0;
    n_tests++;
    if (u_if.o_state !== 3'd0) begin
      n_fail++;
      $display("FAIL ss_arming got st=%0d want 0", u_if.o_state);
    end
  endtask

  task automatic test_reset_mid();
    u_if.i_start = 1'b1;
    tick();
    u_if.i_start = 1'b0;
    do_write(3'd3, 8'd20, 8'd21, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (u_if.o_state !== 3'd0 || u_if.o_pending !== 4'b0000 ||
        u_if.o_dtime_a !== 32'h0A0A0A0A || u_if.o_logic_b !== 4'b1111 ||
        u_if.o_dt_onoff !== 4'b1111) begin
      n_fail++;
      $display("FAIL reset_mid got st=%0d pend=%b a=%h lb=%b dt=%b want 0/0000/0a0a0a0a/1111/1111",
               u_if.o_state, u_if.o_pending, u_if.o_dtime_a, u_if.o_logic_b, u_if.o_dt_onoff);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++;
    if (u_if.o_dtime_a[24 +: 8] !== 8'd10 || u_if.o_pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_lost got a3=%0d pend=%b want 10/0000",
               u_if.o_dtime_a[24 +: 8], u_if.o_pending);
    end
  endtask

  initial begin
    u_if.i_wr_en     = 1'b0;
    u_if.i_wr_leg    = '0;
    u_if.i_wr_dta    = '0;
    u_if.i_wr_dtb    = '0;
    u_if.i_wr_logic  = '0;
    u_if.i_wr_dten   = 1'b0;
    u_if.i_start     = 1'b0;
    u_if.i_stop      = 1'b0;
    u_if.i_sync      = 1'b0;
    u_if.i_fault     = 1'b0;
    u_if.i_fault_clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_idle_write();
    test_clamp();
    test_arm_run();
    test_run_write();
    test_stop();
    test_fault();
    test_wr_err();
    test_start_stop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dt_leg_sequencer.md
Name: dt_leg_sequencer

Overview:
- Controller and configuration owner for NLEGS dead-time generator instances, one per inverter leg.
- Holds shadow copies of each leg's dead times, output polarities and dead-time enable, received from the register-bus side.
- Commits shadow values to the active outputs only at carrier sync boundaries while switching, so a change never lands mid-period.
- Sequences the global pwm_onoff enable: start, synchronized stop, and latched fault shutdown.

Parameters:
- NLEGS, 4, number of legs driven; legal range 1..8.
- DTW, 8, dead-time count width; matches the dead-time generator counter width.
- DT_MIN, 2, minimum dead time in clk cycles, applied when dead time is enabled.
- DT_RST, 10, reset value of every active and shadow dead time.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  single-cycle shadow write strobe.
- wr_leg  in  3  target leg index for the write.
- wr_dta  in  DTW  dead time for output A.
- wr_dtb  in  DTW  dead time for output B.
- wr_logic  in  2  polarities: bit0 is A, bit1 is B; 1 means non-inverted.
- wr_dten  in  1  dead-time enable for the leg; 1 = DT_ON.
- start  in  1  request to begin switching (pulse).
- stop  in  1  request to end switching (pulse).
- sync  in  1  one-cycle carrier boundary pulse (counter zero).
- fault  in  1  external trip, level-sensitive, already synchronized.
- fault_clr  in  1  acknowledge that releases the FAULT state.
- dtime_A  out  NLEGS*DTW  active dead times for A; leg i occupies bits [i*DTW +: DTW].
- dtime_B  out  NLEGS*DTW  active dead times for B.
- logic_A  out  NLEGS  active A polarity per leg.
- logic_B  out  NLEGS  active B polarity per leg.
- dt_onoff  out  NLEGS  active dead-time enable per leg.
- pwm_onoff  out  1  global switching enable.
- pending  out  NLEGS  shadow differs from active / commit outstanding, per leg.
- wr_err  out  1  sticky flag: a write targeted wr_leg >= NLEGS; cleared by fault_clr.
- state  out  3  encoding: IDLE=0, ARMING=1, RUN=2, STOPPING=3, FAULT=4.

Behaviour:
- Reset values:
  - All dtime fields (active and shadow) = DT_RST.
  - logic_A and logic_B all 1; dt_onoff all 1.
  - pending = 0, wr_err = 0, pwm_onoff = 0, state = IDLE.
- Shadow write:
  - wr_en with a valid wr_leg updates that leg's shadow on the next edge and sets pending[wr_leg].
  - An invalid leg is dropped and sets wr_err.
- Clamp at write time: if wr_dten = 1 and a written dead time is below DT_MIN, the stored value is DT_MIN.
  - With wr_dten = 0, values are stored unclamped.
- Commit, shadow to active, for all pending legs; pending is cleared on commit:
  - IDLE and FAULT: one cycle after the write (outputs are off, so the update is safe).
  - ARMING, RUN and STOPPING: on a cycle with sync = 1; values are visible the following cycle.
- Write and sync in the same cycle: the write reaches the shadow but is not part of that commit. It stays pending for the next sync.
- FSM; transitions evaluated each edge in priority order fault > stop > start:
  - IDLE: start with fault = 0 goes to ARMING.
  - ARMING: sync goes to RUN, committing on the same sync. stop returns to IDLE immediately.
  - RUN: stop goes to STOPPING.
  - STOPPING: sync goes to IDLE. A start while in STOPPING is ignored.
  - Any state: fault = 1 goes to FAULT.
  - FAULT: held until fault_clr = 1 and fault = 0, then goes to IDLE. fault_clr while fault = 1 has no effect.
- pwm_onoff = (state is RUN or STOPPING) AND NOT fault.
  - The fault gating is combinational, so pwm_onoff is 0 in the same cycle fault rises.
  - In RUN it goes to 1 on the cycle after the arming sync, and drops the cycle after the stopping sync.
- Start and stop asserted in the same cycle: stop wins (IDLE stays IDLE; ARMING returns to IDLE).
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronous).
  - Shadow contents and pending are lost.

Test Plan:
- Reset, then release: dtime_A and dtime_B all 10, logic all 1, dt_onoff all 1, pwm_onoff = 0, state = 0.
- In IDLE, write leg 2 with dta = 5, dtb = 7, dten = 1: leg 2 fields read 5 and 7 two cycles after wr_en; pending[2] pulses then clears.
- Write dta = 1 with dten = 1: committed value is 2. Same write with dten = 0: committed value is 1.
- start, then sync 20 cycles later: state 1 then 2, pwm_onoff = 1 the cycle after sync.
  - In RUN, write leg 0 with dta = 9: the old value holds until the next sync, then 9; a write in the sync cycle itself is deferred one more sync.
- In RUN, raise fault: pwm_onoff = 0 in the same cycle, state = 4.
  - fault_clr while fault = 1 keeps state 4; drop fault then pulse fault_clr: state 0.
- Write wr_leg = 6 with NLEGS = 4: no output changes, wr_err = 1. start and stop together in IDLE: state stays 0.
